fifo_wptr_ctrl: RTL and testbench

Write-side pointer controller for an asynchronous FIFO.
- Holds the binary write pointer and advances it on accepted writes.
- Sequences the Bin2Gray converter to publish a registered Gray pointer to the read clock domain.
- Synchronises the read domain's Gray pointer into the write domain and derives registered full, almost-full and overflow flags.
- Sits between the write client and the dual-port RAM address/enable pins.

---
 rtl/fifo_ptr_pkg.sv | 30 +++
 rtl/fifo_wptr_ctrl_bin2gray.sv | 16 +
 rtl/fifo_wptr_ctrl.sv | 126 ++++++++++++
 tb/tb_fifo_wptr_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ptr_pkg
// Shared helpers for the asynchronous FIFO pointer controllers (write side now,
// read side later).
//   PTR_W(addr_width) : pointer width, one extra wrap bit above the address.
//   gray2bin(gray)    : Gray -> binary via XOR prefix from the MSB. Operates on
//                       a fixed 32-bit container; callers zero-extend narrower
//                       pointers, which is safe because leading zeros do not
//                       disturb the prefix XOR.
// -----------------------------------------------------------------------------
package fifo_ptr_pkg;

  localparam int MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] ptr_max_t;

  function automatic int PTR_W(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wptr_ctrl_bin2gray.sv
// -----------------------------------------------------------------------------
// Bin2Gray
// Purely combinational binary -> reflected Gray code converter.
//   bin  : binary input, DATA_WIDTH bits
//   gray : Gray output,  DATA_WIDTH bits
// -----------------------------------------------------------------------------
module Bin2Gray #(
  parameter int DATA_WIDTH = 5
) (
  input  logic [DATA_WIDTH-1:0] bin,
  output logic [DATA_WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wptr_ctrl
// Write-side pointer controller for an asynchronous FIFO. Keeps the binary
// write pointer, publishes a registered Gray copy to the read domain, brings the
// read domain's Gray pointer across through a flop chain and derives registered
// full / almost-full / overflow flags.
//
// Ports
//   iClk         write-domain clock
//   iRst_n       asynchronous active-low reset
//   iWrEn        write request from the client
//   iRdPtrGray   read pointer (Gray), read clock domain, unsynchronised
//   oWrAddr      RAM write address (binary pointer LSBs)
//   oRamWe       RAM write strobe, iWrEn & ~oFull (combinational)
//   oWrPtrGray   registered Gray write pointer, to the read domain
//   oFull        registered full flag
//   oAlmostFull  registered, occupancy >= AFULL_THRESH
//   oOverflow    one-cycle pulse for a write attempted while full
//   oLevel       registered occupancy (only when WPTR_LEVEL_EN is defined)
//
// Build option: define WPTR_LEVEL_EN to expose oLevel.
// -----------------------------------------------------------------------------
module fifo_wptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iWrEn,
  input  logic [ADDR_WIDTH:0]   iRdPtrGray,
  output logic [ADDR_WIDTH-1:0] oWrAddr,
  output logic                  oRamWe,
  output logic [ADDR_WIDTH:0]   oWrPtrGray,
  output logic                  oFull,
  output logic                  oAlmostFull,
  output logic                  oOverflow
`ifdef WPTR_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   oLevel
`endif
);

  localparam int PW = PTR_W(ADDR_WIDTH);

  // Gray pointers are "full" when the top two bits differ and the rest match.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] bin_reg;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] sync_reg [SYNC_STAGES];
  logic [PW-1:0] rq_sync;
  logic [PW-1:0] rq_bin;
  logic [PW-1:0] occ_next;
  logic          accept;
  logic          full_next;
  logic          afull_next;

  assign accept   = iWrEn & ~oFull;
  assign bin_next = bin_reg + PW'(accept);

  Bin2Gray #(
    .DATA_WIDTH(PW)
  ) u_bin2gray (
    .bin  (bin_next),
    .gray (gray_next)
  );

  assign rq_sync = sync_reg[SYNC_STAGES-1];
  assign rq_bin  = PW'(gray2bin(ptr_max_t'(rq_sync)));

  // Both evaluated against the pointer *after* this edge's write, so the flags
  // rise on the same edge as the write that fills the FIFO. The read pointer
  // used is the stale synchronised one, which keeps full conservative.
  assign full_next  = (gray_next == (rq_sync ^ FULL_MASK));
  assign occ_next   = bin_next - rq_bin;
  assign afull_next = (occ_next >= AFULL_LVL);

  assign oRamWe  = accept;
  assign oWrAddr = bin_reg[ADDR_WIDTH-1:0];

  // Read-pointer synchroniser: only Gray values enter this chain.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= '0;
      end
    end else begin
      sync_reg[0] <= iRdPtrGray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_reg[i] <= sync_reg[i-1];
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      bin_reg     <= '0;
      oWrPtrGray  <= '0;
      oFull       <= 1'b0;
      oAlmostFull <= 1'b0;
      oOverflow   <= 1'b0;
    end else begin
      bin_reg     <= bin_next;
      oWrPtrGray  <= gray_next;
      oFull       <= full_next;
      oAlmostFull <= afull_next;
      oOverflow   <= iWrEn & oFull;
    end
  end

`ifdef WPTR_LEVEL_EN
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oLevel <= '0;
    end else begin
      oLevel <= occ_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wptr_ctrl
// Self-checking bench for fifo_wptr_ctrl (defaults ADDR_WIDTH=4, SYNC_STAGES=2,
// AFULL_THRESH=12). The reference model tracks plain integer write/read counts;
// occupancy is their difference and the synchroniser is a fixed delay line.
// -----------------------------------------------------------------------------
module tb_fifo_wptr_ctrl;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int SYNC  = 2;
  localparam int AFT   = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [PW-1:0] rd_gray;
  logic [AW-1:0] wr_addr;
  logic          ram_we;
  logic [PW-1:0] wptr_gray;
  logic          full;
  logic          afull;
  logic          ovf;
`ifdef WPTR_LEVEL_EN
  logic [PW-1:0] level;
`endif

  always #5 clk = ~clk;

  fifo_wptr_ctrl #(
    .ADDR_WIDTH   (AW),
    .SYNC_STAGES  (SYNC),
    .AFULL_THRESH (AFT)
  ) dut (
    .iClk        (clk),
    .iRst_n      (rst_n),
    .iWrEn       (wr_en),
    .iRdPtrGray  (rd_gray),
    .oWrAddr     (wr_addr),
    .oRamWe      (ram_we),
    .oWrPtrGray  (wptr_gray),
    .oFull       (full),
    .oAlmostFull (afull),
    .oOverflow   (ovf)
`ifdef WPTR_LEVEL_EN
    ,
    .oLevel      (level)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: counts are unbounded integers.
  int m_wr;
  int rd_cnt;
  int m_level;
  bit m_full;
  bit m_afull;
  bit m_ovf;
  int sync_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] to_gray(input int b);
    int m;
    m = b % (2 * DEPTH);
    return PW'(m ^ (m >> 1));
  endfunction

  task automatic model_reset();
    m_wr    = 0;
    rd_cnt  = 0;
    m_level = 0;
    m_full  = 1'b0;
    m_afull = 1'b0;
    m_ovf   = 1'b0;
    sync_q.delete();
    repeat (SYNC) sync_q.push_back(0);
  endtask

  task automatic check_outputs();
    check_val("wptr_gray", 32'(wptr_gray), 32'(to_gray(m_wr)));
    check_val("wr_addr",   32'(wr_addr),   32'(m_wr % DEPTH));
    check_val("full",      32'(full),      32'(m_full));
    check_val("afull",     32'(afull),     32'(m_afull));
    check_val("overflow",  32'(ovf),       32'(m_ovf));
`ifdef WPTR_LEVEL_EN
    check_val("level",     32'(level),     32'(m_level));
`endif
  endtask

  // One clock of stimulus: drive inputs, check the write strobe, clock, then
  // compare every registered output with the model.
  task automatic step(input bit we, input int rd);
    logic [PW-1:0] prev;
    bit acc;
    int rq;
    int occ;
    wr_en   = we;
    rd_cnt  = rd;
    rd_gray = to_gray(rd);
    #1;
    check_val("ram_we", 32'(ram_we), 32'(we && !m_full));
    prev = wptr_gray;
    @(posedge clk);
    acc  = we && !m_full;
    rq   = sync_q.pop_front();
    sync_q.push_back(rd);
    m_wr    = m_wr + (acc ? 1 : 0);
    occ     = m_wr - rq;
    m_ovf   = we && m_full;
    m_full  = (occ == DEPTH);
    m_afull = (occ >= AFT);
    m_level = occ;
    #1;
    check_outputs();
    check_val("gray_bits_changed", 32'($countones(prev ^ wptr_gray)), acc ? 32'd1 : 32'd0);
    $display("cyc t=%0t we=%0d rd=%0d acc=%0d wr=%0d gray=%b full=%0d afull=%0d ovf=%0d",
             $time, we, rd, acc, m_wr, wptr_gray, full, afull, ovf);
  endtask

  task automatic pulse_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_gray = '0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int nr;
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_gray = '0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-stream asynchronous reset after 5 writes.
    for (int i = 0; i < 5; i++) step(1'b1, 0);
    rst_n = 1'b0;
    #1;
    check_val("rst_async_gray", 32'(wptr_gray), 32'd0);
    check_val("rst_async_addr", 32'(wr_addr),   32'd0);
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 0);
    check_val("first_write_gray", 32'(wptr_gray), 32'b00001);
    check_val("first_write_addr", 32'(wr_addr),   32'd1);

    // Fill 16 back-to-back with the read pointer parked at 0.
    pulse_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 0);
      if (i == AFT - 1) check_val("afull_before_thresh", 32'(afull), 32'd0);
      if (i == AFT)     check_val("afull_at_thresh",     32'(afull), 32'd1);
      if (i == DEPTH - 1) check_val("full_before_last",  32'(full),  32'd0);
    end
    check_val("full_after_16", 32'(full), 32'd1);
    check_val("gray_full",     32'(wptr_gray), 32'b11000);

    // Writes while full.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0);
      check_val("overflow_pulse",   32'(ovf),       32'd1);
      check_val("gray_frozen_full", 32'(wptr_gray), 32'b11000);
    end
    step(1'b0, 0);
    check_val("overflow_clear", 32'(ovf), 32'd0);

    // Read pointer advances to 1: full drops on the 3rd edge.
    step(1'b0, 1);
    check_val("full_lat_edge1", 32'(full), 32'd1);
    step(1'b0, 1);
    check_val("full_lat_edge2", 32'(full), 32'd1);
    step(1'b0, 1);
    check_val("full_lat_edge3", 32'(full), 32'd0);
    step(1'b1, 1);
    check_val("write_after_unfull", 32'(wptr_gray), 32'b11001);

    // Drain, then let the read side track writes across the pointer wrap.
    for (int r = 2; r <= m_wr; r++) step(1'b0, r);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, m_wr);
      if (m_wr % (2 * DEPTH) == 0) check_val("wrap_gray_zero", 32'(wptr_gray), 32'd0);
      if (i % 4 == 3) step(1'b0, m_wr);
    end

    // Randomised traffic with a legal, one-step-at-a-time read pointer.
    for (int i = 0; i < 400; i++) begin
      nr = rd_cnt;
      if (rd_cnt < m_wr && $urandom_range(0, 99) < 40) nr = rd_cnt + 1;
      step($urandom_range(0, 99) < 65, nr);
    end

`ifdef WPTR_LEVEL_EN
    pulse_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 0);
    for (int r = 1; r <= 3; r++) step(1'b0, r);
    for (int i = 0; i < 3; i++) step(1'b0, 3);
    check_val("level_settled", 32'(level), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
